// File: rtl/adler32_pkg.sv
// Shared types and constants for the Adler-32 frame transmitter.
// Holds the FSM state encoding plus byte/length typedefs.
package adler32_pkg;

    typedef enum logic [2:0] {
        FILL,
        SEND_SIZE,
        SEND_START,
        SEND_DATA,
        WAIT_SUM,
        DONE
    } state_t;

    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] len_t;

endpackage

// File: rtl/adler32_tx_buf.sv
// Frame buffer: simple dual-port DEPTH x 8 RAM.
// Ports: clock; wr_en/wr_addr/wr_data (sync write);
// rd_addr in, rd_data out one cycle later (registered read).
module adler32_tx_buf #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/adler32_frame_tx.sv
// Buffers one upstream frame, drives it into the Adler-32 engine
// (size_valid/size, data_start, data) and reports the checksum back.
// Ports: clock, rst (sync, active high);
// upstream in_valid/in_ready/in_data/in_last;
// engine size_valid/size/data_start/data, checksum_valid/checksum;
// result_valid/result_checksum/result_len/result_trunc/result_error.
module adler32_frame_tx
    import adler32_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        size_valid,
    output logic [31:0] size,
    output logic        data_start,
    output logic [7:0]  data,
    input  logic        checksum_valid,
    input  logic [31:0] checksum,
    output logic        result_valid,
    output logic [31:0] result_checksum,
    output logic [31:0] result_len,
    output logic        result_trunc,
    output logic        result_error
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] FULL  = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nx;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_nx;
    logic [LEN_W-1:0]   sent;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   tcnt;
    logic               trunc;
    byte_t              rd_data;

    logic               accept;
    logic               full_hit;
    logic               close;
    logic               sum_hit;
    logic               timeout_hit;

    logic               in_ready_nx;
    logic               size_valid_nx;
    len_t               size_nx;
    logic               data_start_nx;
    byte_t              data_nx;
    logic               result_valid_nx;

    adler32_tx_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign accept      = in_valid && in_ready && (state == FILL);
    assign full_hit    = (len + 1'b1) == FULL;
    assign close       = accept && (in_last || full_hit);
    assign sum_hit     = (state == WAIT_SUM) && checksum_valid;
    assign timeout_hit = (state == WAIT_SUM) && !checksum_valid
                         && (tcnt == TLAST);

    always_comb begin
        len_nx = len;
        if (state == DONE) begin
            len_nx = '0;
        end else if (accept) begin
            len_nx = len + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:       if (close) state_nx = SEND_SIZE;
            SEND_SIZE:  state_nx = SEND_START;
            SEND_START: state_nx = SEND_DATA;
            SEND_DATA:  if (sent == len - 1'b1) state_nx = WAIT_SUM;
            WAIT_SUM:   if (sum_hit || timeout_hit) state_nx = DONE;
            DONE:       state_nx = FILL;
            default:    state_nx = FILL;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= FILL;
            len    <= '0;
            sent   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tcnt   <= '0;
            trunc  <= 1'b0;
        end else begin
            state <= state_nx;
            len   <= len_nx;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full_hit && !in_last) begin
                    trunc <= 1'b1;
                end
            end
            // Read address runs two cycles ahead of the data output:
            // one for the RAM read register, one for the data register.
            if (state == SEND_SIZE || state == SEND_START
                || state == SEND_DATA) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (state == SEND_DATA) begin
                sent <= sent + 1'b1;
            end
            if (state == WAIT_SUM) begin
                tcnt <= tcnt + 1'b1;
            end
            if (state == DONE) begin
                sent   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                tcnt   <= '0;
                trunc  <= 1'b0;
            end
        end
    end

    // Output decode, from the state being entered so every
    // protocol output can be registered.
    always_comb begin
        in_ready_nx     = (state_nx == FILL) && (len_nx != FULL);
        size_valid_nx   = (state_nx == SEND_SIZE);
        size_nx         = size_valid_nx ? len_t'(len_nx) : '0;
        data_start_nx   = (state_nx == SEND_START);
        data_nx         = (state_nx == SEND_DATA) ? rd_data : '0;
        result_valid_nx = (state_nx == DONE);
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (rst) begin
            in_ready        <= 1'b0;
            size_valid      <= 1'b0;
            size            <= '0;
            data_start      <= 1'b0;
            data            <= '0;
            result_valid    <= 1'b0;
            result_checksum <= '0;
            result_len      <= '0;
            result_trunc    <= 1'b0;
            result_error    <= 1'b0;
        end else begin
            in_ready     <= in_ready_nx;
            size_valid   <= size_valid_nx;
            size         <= size_nx;
            data_start   <= data_start_nx;
            data         <= data_nx;
            result_valid <= result_valid_nx;
            if (result_valid_nx) begin
                result_checksum <= sum_hit ? checksum : '0;
                result_len      <= len_t'(len);
                result_trunc    <= trunc;
                result_error    <= !sum_hit;
            end
        end
    end

endmodule

// File: tb/tb_adler32_frame_tx.sv
// Self-checking bench for adler32_frame_tx with a behavioural
// Adler-32 engine model and a byte-queue reference checksum.
module tb_adler32_frame_tx;
    import adler32_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] size;
        int          t_size;
        int          t_start;
        int          first;
        int          last;
        int          n;
        logic [31:0] rx;
    } frame_t;

    typedef struct {
        logic [31:0] ck;
        logic [31:0] len;
        logic        trunc;
        logic        err;
        int          t;
    } res_t;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        size_valid;
    logic [31:0] size;
    logic        data_start;
    logic [7:0]  data;
    logic        checksum_valid = 1'b0;
    logic [31:0] checksum = 32'h0;
    logic        result_valid;
    logic [31:0] result_checksum;
    logic [31:0] result_len;
    logic        result_trunc;
    logic        result_error;

    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     proto_err = 0;
    bit     sink_on = 1'b1;
    frame_t frames[$];
    res_t   results[$];
    int     ck_t[$];

    adler32_frame_tx #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .size_valid      (size_valid),
        .size            (size),
        .data_start      (data_start),
        .data            (data),
        .checksum_valid  (checksum_valid),
        .checksum        (checksum),
        .result_valid    (result_valid),
        .result_checksum (result_checksum),
        .result_len      (result_len),
        .result_trunc    (result_trunc),
        .result_error    (result_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] adler(input bq_t b);
        int unsigned a;
        int unsigned s;
        a = ADLER_INIT & 32'hFFFF;
        s = ADLER_INIT >> 16;
        foreach (b[i]) begin
            a = (a + b[i]) % 65521;
            s = (s + a) % 65521;
        end
        return {s[15:0], a[15:0]};
    endfunction

    // Engine model: takes size, collects size bytes after data_start,
    // strobes the checksum of what it received one cycle later.
    initial begin : engine
        int          need;
        bit          pending;
        logic [31:0] psum;
        bq_t         rxq;
        frame_t      fr;
        res_t        r;
        need = 0;
        pending = 0;
        psum = 0;
        fr = '{default: 0};
        forever begin
            @(negedge clock);
            checksum_valid = 1'b0;
            checksum = 32'h0;
            if (rst) begin
                need = 0;
                pending = 0;
                rxq.delete();
            end else begin
                if (pending && sink_on) begin
                    checksum_valid = 1'b1;
                    checksum = psum;
                    ck_t.push_back(cyc);
                end
                pending = 0;
                if (need > 0) begin
                    rxq.push_back(data);
                    need--;
                    if (need == 0) begin
                        psum = adler(rxq);
                        pending = 1;
                        fr.last = cyc;
                        fr.n = rxq.size();
                        fr.rx = psum;
                        frames.push_back(fr);
                    end
                end else if (data !== 8'h00) begin
                    proto_err++;
                end
                if (size_valid) begin
                    fr.size = size;
                    fr.t_size = cyc;
                end else if (size !== 32'h0) begin
                    proto_err++;
                end
                if (data_start) begin
                    fr.t_start = cyc;
                    fr.first = cyc + 1;
                    need = (size_valid || fr.size > 64) ? 64 : int'(fr.size);
                    rxq.delete();
                end
                if (result_valid) begin
                    r.ck = result_checksum;
                    r.len = result_len;
                    r.trunc = result_trunc;
                    r.err = result_error;
                    r.t = cyc;
                    results.push_back(r);
                end
            end
        end
    end

    task automatic send(input bq_t b, input bit last, input int gap_pct,
                        input bit force_gap, output int first_stall,
                        output bit ok);
        int i;
        int budget;
        bit prev;
        i = 0;
        budget = 3000;
        prev = 0;
        first_stall = -1;
        ok = 1;
        while (i < b.size()) begin
            @(negedge clock);
            if (budget == 0) begin
                ok = 0;
                break;
            end
            budget--;
            if (!in_ready && first_stall < 0) first_stall = i;
            if (in_ready && !(force_gap && prev)
                && ($urandom_range(99) >= gap_pct)) begin
                in_valid = 1'b1;
                in_data = b[i];
                in_last = last && (i == b.size() - 1);
                i++;
                prev = 1;
            end else begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                in_last = 1'($urandom);
                prev = 0;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic get_result(output frame_t f, output res_t r,
                              output bit ok);
        int budget;
        budget = 400;
        ok = 0;
        f = '{default: 0};
        r = '{default: 0};
        while (budget > 0 && results.size() == 0) begin
            @(negedge clock);
            budget--;
        end
        if (results.size() > 0) begin
            r = results.pop_front();
            ok = 1;
            if (frames.size() > 0) f = frames.pop_front();
        end
    endtask

    task automatic wait_ready();
        int budget;
        budget = 100;
        @(negedge clock);
        while (budget > 0 && !in_ready) begin
            @(negedge clock);
            budget--;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if ({in_ready, size_valid, size, data_start, data, result_valid,
             result_checksum, result_len, result_trunc,
             result_error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b sv=%b size=%h ds=%b d=%h rv=%b ck=%h len=%h",
                     in_ready, size_valid, size, data_start, data,
                     result_valid, result_checksum, result_len);
        end
        rst = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        bq_t q;
        frame_t f;
        res_t r;
        int st;
        bit ok;
        q.push_back(8'h61);
        send(q, 1, 0, 0, st, ok);
        get_result(f, r, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_result: no result_valid within budget");
            return;
        end
        vectors++;
        if (f.size !== 32'd1) begin
            miscompares++;
            $display("FAIL single_size: got %0d want 1", f.size);
        end
        vectors++;
        if (f.t_start != f.t_size + 1 || f.first != f.t_size + 2) begin
            miscompares++;
            $display("FAIL single_timing: size@%0d start@%0d",
                     f.t_size, f.t_start);
        end
        vectors++;
        if (f.rx !== 32'h0062_0062 || r.ck !== 32'h0062_0062) begin
            miscompares++;
            $display("FAIL single_cksum: engine %h result %h want 00620062",
                     f.rx, r.ck);
        end
        vectors++;
        if (r.len !== 32'd1 || r.trunc !== 1'b0 || r.err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_flags: len=%0d trunc=%b err=%b want 1/0/0",
                     r.len, r.trunc, r.err);
        end
        vectors++;
        if (r.t != f.last + 2) begin
            miscompares++;
            $display("FAIL single_latency: result@%0d want %0d",
                     r.t, f.last + 2);
        end
    endtask

    task automatic test_abc();
        bq_t q;
        frame_t f;
        res_t r;
        int st;
        bit ok;
        q = '{8'h61, 8'h62, 8'h63};
        send(q, 1, 0, 1, st, ok);
        get_result(f, r, ok);
        vectors++;
        if (!ok || f.n != 3 || f.rx !== 32'h024D_0127) begin
            miscompares++;
            $display("FAIL abc_stream: ok=%b n=%0d engine %h want 024d0127",
                     ok, f.n, f.rx);
        end
        vectors++;
        if (r.ck !== 32'h024D_0127 || r.len !== 32'd3) begin
            miscompares++;
            $display("FAIL abc_result: ck=%h len=%0d want 024d0127/3",
                     r.ck, r.len);
        end
    endtask

    task automatic test_wikipedia();
        bq_t q;
        frame_t f;
        res_t r;
        string s;
        int st;
        bit ok;
        s = "Wikipedia";
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send(q, 1, 30, 0, st, ok);
        get_result(f, r, ok);
        vectors++;
        if (!ok || r.ck !== 32'h11E6_0398 || r.len !== 32'd9) begin
            miscompares++;
            $display("FAIL wiki_result: ok=%b ck=%h len=%0d want 11e60398/9",
                     ok, r.ck, r.len);
        end
        vectors++;
        if (f.size !== 32'd9 || r.err !== 1'b0) begin
            miscompares++;
            $display("FAIL wiki_size: size=%0d err=%b want 9/0",
                     f.size, r.err);
        end
    endtask

    task automatic test_trunc();
        bq_t q;
        bq_t q1;
        bq_t q2;
        frame_t f;
        res_t r;
        int st;
        bit ok;
        for (int i = 0; i < DEPTH + 2; i++) begin
            q.push_back(8'($urandom));
            if (i < DEPTH) q1.push_back(q[i]);
            else q2.push_back(q[i]);
        end
        wait_ready();
        send(q, 1, 0, 0, st, ok);
        vectors++;
        if (!ok || st != DEPTH) begin
            miscompares++;
            $display("FAIL trunc_ready: in_ready first low after %0d accepts, want %0d",
                     st, DEPTH);
        end
        get_result(f, r, ok);
        vectors++;
        if (!ok || f.size !== 32'(DEPTH) || r.len !== 32'(DEPTH)
            || r.trunc !== 1'b1) begin
            miscompares++;
            $display("FAIL trunc_frame1: size=%0d len=%0d trunc=%b want %0d/%0d/1",
                     f.size, r.len, r.trunc, DEPTH, DEPTH);
        end
        vectors++;
        if (r.ck !== adler(q1)) begin
            miscompares++;
            $display("FAIL trunc_cksum1: got %h want %h", r.ck, adler(q1));
        end
        get_result(f, r, ok);
        vectors++;
        if (!ok || r.len !== 32'd2 || r.trunc !== 1'b0
            || r.ck !== adler(q2)) begin
            miscompares++;
            $display("FAIL trunc_frame2: len=%0d trunc=%b ck=%h want 2/0/%h",
                     r.len, r.trunc, r.ck, adler(q2));
        end
    endtask

    task automatic test_timeout();
        bq_t q;
        frame_t f;
        res_t r;
        int st;
        bit ok;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        sink_on = 1'b0;
        send(q, 1, 0, 0, st, ok);
        get_result(f, r, ok);
        vectors++;
        if (!ok || r.err !== 1'b1 || r.ck !== 32'h0 || r.len !== 32'd4) begin
            miscompares++;
            $display("FAIL timeout_flags: ok=%b err=%b ck=%h len=%0d want 1/0/4",
                     ok, r.err, r.ck, r.len);
        end
        vectors++;
        if (r.t - f.last != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_delay: got %0d cycles want %0d",
                     r.t - f.last, TIMEOUT + 1);
        end
        while (cyc < r.t + 1) @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ready: got %b want 1", in_ready);
        end
        sink_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        bq_t q;
        bq_t qa;
        frame_t f;
        res_t r;
        int st;
        int budget;
        bit ok;
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(255, 1)));
        send(q, 1, 0, 0, st, ok);
        budget = 50;
        while (budget > 0 && !data_start) begin
            @(negedge clock);
            budget--;
        end
        vectors++;
        if (data_start !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_start: data_start not seen");
        end
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 rst = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if ({in_ready, size_valid, size, data_start, data, result_valid,
             result_checksum, result_len, result_trunc,
             result_error} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: ready=%b d=%h rv=%b ck=%h len=%0d err=%b",
                     in_ready, data, result_valid, result_checksum,
                     result_len, result_error);
        end
        rst = 1'b0;
        frames.delete();
        results.delete();
        ck_t.delete();
        @(posedge clock);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_ready: got %b want 1", in_ready);
        end
        repeat (40) @(negedge clock);
        vectors++;
        if (results.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_noresult: got %0d results want 0",
                     results.size());
        end
        qa.push_back(8'h61);
        send(qa, 1, 0, 0, st, ok);
        get_result(f, r, ok);
        vectors++;
        if (!ok || r.ck !== 32'h0062_0062 || r.len !== 32'd1) begin
            miscompares++;
            $display("FAIL rstmid_next: ck=%h len=%0d want 00620062/1",
                     r.ck, r.len);
        end
    endtask

    task automatic test_back_to_back();
        bq_t q1;
        bq_t q2;
        frame_t f1;
        frame_t f2;
        res_t r1;
        res_t r2;
        int st;
        int t_ck;
        bit ok1;
        bit ok2;
        ck_t.delete();
        for (int i = 0; i < 3; i++) q1.push_back(8'($urandom));
        q2.push_back(8'($urandom));
        send(q1, 1, 0, 0, st, ok1);
        send(q2, 1, 0, 0, st, ok2);
        get_result(f1, r1, ok1);
        get_result(f2, r2, ok2);
        vectors++;
        if (!ok1 || !ok2 || r1.ck !== adler(q1) || r2.ck !== adler(q2)) begin
            miscompares++;
            $display("FAIL b2b_cksum: got %h %h want %h %h",
                     r1.ck, r2.ck, adler(q1), adler(q2));
        end
        t_ck = (ck_t.size() > 0) ? ck_t[0] : 0;
        vectors++;
        if (ck_t.size() == 0 || f2.t_size - t_ck < 3) begin
            miscompares++;
            $display("FAIL b2b_gap: size_valid %0d cycles after checksum_valid, want >=3",
                     f2.t_size - t_ck);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            bq_t q;
            frame_t f;
            res_t r;
            int n;
            int st;
            bit ok;
            n = $urandom_range(DEPTH, 1);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send(q, 1, 30, 0, st, ok);
            get_result(f, r, ok);
            vectors++;
            if (!ok || r.ck !== adler(q) || r.len !== 32'(n)
                || r.trunc !== (n == DEPTH ? 1'b0 : 1'b0)
                || r.err !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d: ck=%h len=%0d trunc=%b err=%b want %h/%0d/0/0",
                         k, r.ck, r.len, r.trunc, r.err, adler(q), n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_abc();
        test_wikipedia();
        test_trunc();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        vectors++;
        if (proto_err != 0) begin
            miscompares++;
            $display("FAIL protocol_idle: %0d nonzero size/data outside window, want 0",
                     proto_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adler32_frame_tx.md
Name: adler32_frame_tx

Overview:
Frame transmitter that drives the Adler-32 engine's input protocol (size_valid/size, data_start, data) from an upstream byte stream. It buffers one frame, announces its length, plays the bytes out back-to-back, then captures the engine's checksum_valid/checksum and reports the result upstream. It sits between a valid/ready byte source and the adler32 checksum core.

Parameters:
DEPTH, 256, frame buffer size in bytes (power of 2, >=2); maximum frame length
ADDR_W, $clog2(DEPTH), buffer address width (derived, not overridden)
TIMEOUT, 16, cycles to wait for checksum_valid after the last data byte before flagging an error

Ports:
clock  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream byte valid
in_ready  out  1  upstream byte accept; high only in FILL while buffer not full
in_data  in  8  upstream byte
in_last  in  1  marks final byte of frame (qualified by in_valid&&in_ready)
size_valid  out  1  one-cycle pulse to engine: frame length valid
size  out  32  frame length, zero-extended; 0 when size_valid low
data_start  out  1  one-cycle pulse to engine, cycle after size_valid
data  out  8  payload byte to engine; 0 outside SEND_DATA
checksum_valid  in  1  engine result strobe
checksum  in  32  engine result {B,A}
result_valid  out  1  one-cycle pulse: frame complete
result_checksum  out  32  captured checksum; 0 on timeout
result_len  out  32  bytes sent in frame
result_trunc  out  1  frame was force-closed at DEPTH (no in_last)
result_error  out  1  checksum_valid not seen within TIMEOUT

Behaviour:
- Reset (synchronous, active-high): state=FILL, length=0, pointers=0, timeout counter=0; all outputs 0 except in_ready=1 the cycle after reset deasserts. Buffer contents undefined, treated as empty. Reset mid-frame abandons the frame with no result pulse; the engine is reset in the same cycle.
- FILL: in_ready=1. Each in_valid&&in_ready writes in_data to buf[wr_ptr] and increments len. Frame closes when in_last is accepted or len reaches DEPTH. In the DEPTH case, trunc=1 and in_ready drops the next cycle. Zero-length frames cannot occur, since in_last rides a byte. Next state SEND_SIZE.
- SEND_SIZE (1 cycle, call it T): size_valid=1, size=len. Prefetch buf[0].
- SEND_START (T+1): data_start=1. The engine consumes no byte this cycle.
- SEND_DATA (T+2 .. T+1+len): data=buf[i] for i=0..len-1 on consecutive cycles with no gaps. Next state WAIT_SUM.
- WAIT_SUM: the timeout counter increments per cycle.
  - On checksum_valid (nominally T+2+len): latch checksum, go to DONE.
  - If the counter reaches TIMEOUT first: result_checksum=0, error=1, go to DONE.
  - checksum_valid outside WAIT_SUM is ignored.
- DONE (1 cycle): result_valid=1 together with result_checksum, result_len, result_trunc and result_error. All result_* fields hold until the next DONE. Then return to FILL, clear len/pointers/trunc, set in_ready=1.
- Engine recovery: the engine needs 2 cycles after checksum_valid before it samples size_valid again. The DONE+FILL path guarantees at least 3.
- All protocol outputs are registered. in_ready is registered, with a state/fullness decode.

Decomposition:
- Shared package adler32_pkg:
  - state enum {FILL, SEND_SIZE, SEND_START, SEND_DATA, WAIT_SUM, DONE}
  - ADLER_INIT=32'h0000_0001
  - byte_t (8-bit) and len_t (32-bit) typedefs
- One sub-module: adler32_tx_buf, a simple dual-port DEPTH x 8 RAM with synchronous write and registered read.

Test Plan:
- Single byte 0x61 ("a"), in_last=1. Required: size_valid at T with size=1; data_start at T+1; data=0x61 at T+2; engine returns 0x00620062; result_valid with result_len=1, result_checksum=0x00620062, trunc=0, error=0.
- "abc" (0x61,0x62,0x63) with an in_valid gap between bytes. Required: data plays out on 3 consecutive cycles; result_checksum=0x024D0127, result_len=3.
- "Wikipedia" (9 bytes). Required: result_checksum=0x11E60398, result_len=9.
- DEPTH=4, six bytes without in_last. Required: in_ready low after the 4th accept; size=4; result_trunc=1. Bytes 5-6 are then accepted into the next frame.
- Sink model never asserts checksum_valid. Required: result_valid exactly TIMEOUT+1 cycles after the last data byte, with error=1 and result_checksum=0; then in_ready=1.
- rst asserted during SEND_DATA of a 5-byte frame. Required: next cycle all outputs 0 and no result_valid. Next "a" frame yields 0x00620062.
- Two frames back-to-back. Required: second size_valid comes at least 3 cycles after the first checksum_valid, and both checksums are correct.
